tt_sweep_ctrl: RTL and testbench

Sequencer that extracts the complete truth table of one combinational (or pipelined) NIN-input Boolean function block in the classification datapath. It drives the block's inputs x0..x(NIN-1) through all 2^NIN minterms in ascending order and captures the block's single output bit into a truth-table register. It also computes the on-set size and compares the result against an expected table. The result is handed downstream with a valid/ready handshake. It sits between the test/classification host and each majority-gate function instance.

---
 rtl/tt_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// Walks x through every minterm of an NIN-input function block, capturing f_in into tt with a
// running popcount and expected-table compare; result held on tt_valid until tt_ready.
module tt_sweep_ctrl #(
  parameter int NIN  = 7,
  parameter int PIPE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [(1<<NIN)-1:0]  exp_tt,
  output logic [NIN-1:0]       x,
  input  logic                 f_in,
  output logic                 busy,
  output logic [(1<<NIN)-1:0]  tt,
  output logic [NIN:0]         ones,
  output logic                 match,
  output logic                 tt_valid,
  input  logic                 tt_ready
);

  localparam int NT = 1 << NIN;
  localparam logic [NIN-1:0] X_LAST = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, HOLD} state_t;

  state_t          state;
  logic [NT-1:0]   exp_q;
  logic            cap_vld;
  logic [NIN-1:0]  cap_idx;
  logic            cap_en;
  logic [NT-1:0]   tt_nxt;
  logic [NIN:0]    ones_nxt;

  // The capture tag trails x by PIPE edges so each f_in sample lands on the minterm that produced it.
  generate
    if (PIPE == 0) begin : g_nopipe
      assign cap_vld = (state == SWEEP);
      assign cap_idx = x;
    end else begin : g_pipe
      logic [NIN-1:0] tag_idx [PIPE];
      logic [PIPE-1:0] tag_vld;

      always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
          tag_vld <= '0;
          for (int i = 0; i < PIPE; i++) tag_idx[i] <= '0;
        end else begin
          tag_vld[0] <= (state == SWEEP);
          tag_idx[0] <= x;
          for (int i = 1; i < PIPE; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_idx[i] <= tag_idx[i-1];
          end
        end
      end

      assign cap_vld = tag_vld[PIPE-1];
      assign cap_idx = tag_idx[PIPE-1];
    end
  endgenerate

  assign cap_en = cap_vld && !abort && ((state == SWEEP) || (state == DRAIN));

  always_comb begin
    tt_nxt   = tt;
    ones_nxt = ones;
    if (cap_en) begin
      tt_nxt[cap_idx] = f_in;
      ones_nxt        = ones + {{NIN{1'b0}}, f_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      x        <= '0;
      tt       <= '0;
      ones     <= '0;
      match    <= 1'b0;
      tt_valid <= 1'b0;
      busy     <= 1'b0;
      exp_q    <= '0;
    end else if (abort) begin
      // Partial tt/ones are left in place; tt_valid low marks them as unusable.
      state    <= IDLE;
      x        <= '0;
      tt_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tt   <= tt_nxt;
      ones <= ones_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SWEEP;
            busy  <= 1'b1;
            x     <= '0;
            tt    <= '0;
            ones  <= '0;
            match <= 1'b0;
            exp_q <= exp_tt;
          end
        end
        SWEEP: begin
          if (x == X_LAST) begin
            x <= '0;
            if (PIPE == 0) begin
              state    <= HOLD;
              tt_valid <= 1'b1;
              match    <= (tt_nxt == exp_q);
            end else begin
              state <= DRAIN;
            end
          end else begin
            x <= x + 1'b1;
          end
        end
        DRAIN: begin
          if (cap_vld && (cap_idx == X_LAST)) begin
            state    <= HOLD;
            tt_valid <= 1'b1;
            match    <= (tt_nxt == exp_q);
          end
        end
        HOLD: begin
          if (tt_ready) begin
            state    <= IDLE;
            tt_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Drives a combinational (PIPE=0) and a two-register (PIPE=2) function instance side by side
// from one stimulus stream; a sweep-level model predicts every output each cycle.
module tb_tt_sweep_ctrl;

  localparam int NT = 128;
  localparam int PV [2] = '{0, 2};

  logic         clk = 1'b0;
  logic         rst_n, start, abort, tt_ready;
  logic [127:0] exp_tt;
  int           mode;

  logic [6:0]   xo  [2];
  logic         fi  [2];
  logic         bsy [2];
  logic [127:0] tto [2];
  logic [7:0]   on  [2];
  logic         mt  [2];
  logic         tv  [2];
  logic [6:0]   d1 = '0, d2 = '0;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  tt_sweep_ctrl #(.NIN(7), .PIPE(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
    .x(xo[0]), .f_in(fi[0]), .busy(bsy[0]), .tt(tto[0]), .ones(on[0]),
    .match(mt[0]), .tt_valid(tv[0]), .tt_ready(tt_ready));

  tt_sweep_ctrl #(.NIN(7), .PIPE(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
    .x(xo[1]), .f_in(fi[1]), .busy(bsy[1]), .tt(tto[1]), .ones(on[1]),
    .match(mt[1]), .tt_valid(tv[1]), .tt_ready(tt_ready));

  function automatic logic fval(input int md, input logic [6:0] v);
    case (md)
      0: return v[0];
      1: return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
      2: return 1'b1;
      3: return 1'b0;
      default: return v[6];
    endcase
  endfunction

  // Low cnt bits of the function's truth table; the rest not yet captured (still 0).
  function automatic logic [127:0] table_upto(input int md, input int cnt);
    logic [127:0] t;
    t = '0;
    for (int k = 0; k < NT; k++) if (k < cnt) t[k] = fval(md, 7'(k));
    return t;
  endfunction

  function automatic int popc(input logic [127:0] v);
    int n;
    n = 0;
    for (int k = 0; k < NT; k++) n += int'(v[k]);
    return n;
  endfunction

  assign fi[0] = fval(mode, xo[0]);
  assign fi[1] = fval(mode, d2);

  always @(posedge clk) begin
    d1 <= xo[1];
    d2 <= d1;
  end

  // Model: n = edges since the accepted start; minterm k lands at edge k+1+PIPE.
  bit           m_run  [2];
  int           m_n    [2];
  int           m_cnt  [2];
  int           m_mode [2];
  logic [127:0] m_exp  [2];

  initial for (int d = 0; d < 2; d++) begin
    m_run[d] = 1'b0; m_n[d] = 0; m_cnt[d] = 0; m_mode[d] = 0; m_exp[d] = '0;
  end

  function automatic bit m_valid(input int d);
    return m_run[d] && (m_n[d] >= NT + PV[d]);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_run[d] <= 1'b0; m_n[d] <= 0; m_cnt[d] <= 0; m_exp[d] <= '0;
      end else if (!m_run[d]) begin
        if (start && !abort) begin
          m_run[d] <= 1'b1; m_n[d] <= 0; m_cnt[d] <= 0;
          m_mode[d] <= mode; m_exp[d] <= exp_tt;
        end
      end else if (abort) begin
        m_run[d] <= 1'b0;
      end else if (m_valid(d) && tt_ready) begin
        m_run[d] <= 1'b0;
      end else begin
        m_n[d]   <= m_n[d] + 1;
        m_cnt[d] <= (m_n[d] + 1 - PV[d] < 0) ? 0 :
                    (m_n[d] + 1 - PV[d] > NT) ? NT : m_n[d] + 1 - PV[d];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("p%0d.busy", PV[d]), 128'(bsy[d]), 128'(m_run[d]));
        chk($sformatf("p%0d.x", PV[d]), 128'(xo[d]),
            (m_run[d] && m_n[d] < NT) ? 128'(m_n[d]) : 128'd0);
        chk($sformatf("p%0d.tt_valid", PV[d]), 128'(tv[d]), 128'(m_valid(d)));
        chk($sformatf("p%0d.tt", PV[d]), tto[d], table_upto(m_mode[d], m_cnt[d]));
        chk($sformatf("p%0d.ones", PV[d]), 128'(on[d]),
            128'(popc(table_upto(m_mode[d], m_cnt[d]))));
        if (m_valid(d))
          chk($sformatf("p%0d.match", PV[d]), 128'(mt[d]),
              128'(table_upto(m_mode[d], NT) == m_exp[d]));
      end
    end
  end

  task automatic do_start(input int md, input logic [127:0] e);
    @(negedge clk);
    mode = md; exp_tt = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the first negedge after the start edge; counts edges until each result appears.
  task automatic wait_valid(input int lat0, input int lat2);
    int c, c0, c2;
    c = 0; c0 = -1; c2 = -1;
    while (c < 300 && c2 < 0) begin
      if (tv[0] && c0 < 0) c0 = c;
      if (tv[1] && c2 < 0) c2 = c;
      if (c2 < 0) begin
        @(negedge clk);
        c++;
      end
    end
    chk("latency_p0", 128'(c0), 128'(lat0));
    chk("latency_p2", 128'(c2), 128'(lat2));
  endtask

  task automatic accept;
    tt_ready = 1'b1;
    @(negedge clk);
    tt_ready = 1'b0;
    chk("idle_after_accept", 128'({bsy[0], bsy[1]}), 128'd0);
  endtask

  task automatic wait_x(input int target);
    int c;
    c = 0;
    while (c < 200 && xo[0] != 7'(target)) begin
      @(negedge clk);
      c++;
    end
    chk("reach_x", 128'(xo[0]), 128'(target));
  endtask

  initial begin
    logic [127:0] e;
    bit seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tt_ready = 1'b0; mode = 0; exp_tt = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 128'({bsy[0], bsy[1]}), 128'd0);
    chk("reset_tt", tto[0] | tto[1], 128'd0);
    chk("reset_outs", 128'({xo[0], on[0], mt[0], tv[0], tv[1]}), 128'd0);
    chk_on = 1'b1;
    rst_n = 1'b1;

    // x0 pass-through, with a 10-cycle stall in HOLD and a stray start
    do_start(0, {16{8'hAA}});
    wait_valid(128, 130);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("hold_tt_p0", tto[0], {16{8'hAA}});
    chk("hold_ones_p0", 128'(on[0]), 128'd64);
    chk("hold_busy", 128'({bsy[0], bsy[1]}), 128'd3);
    accept();

    do_start(1, {16{8'hE8}});
    wait_valid(128, 130);
    chk("maj_tt_p2", tto[1], {16{8'hE8}});
    chk("maj_match", 128'({mt[0], mt[1]}), 128'd3);
    accept();

    e = {16{8'hE8}};
    e[77] = ~e[77];
    do_start(1, e);
    wait_valid(128, 130);
    chk("maj_flip_match", 128'({mt[0], mt[1]}), 128'd0);
    accept();

    do_start(2, '1);
    wait_valid(128, 130);
    chk("const1_ones", 128'(on[0]), 128'h80);
    chk("const1_tt", tto[1], {128{1'b1}});
    accept();

    do_start(3, '0);
    wait_valid(128, 130);
    chk("const0_ones", 128'({on[0], on[1]}), 128'd0);
    accept();

    do_start(4, '0);
    wait_valid(128, 130);
    chk("x6_tt_p2", tto[1], {{64{1'b1}}, {64{1'b0}}});
    accept();

    // start with abort in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 128'({bsy[0], bsy[1]}), 128'd0);

    do_start(2, '1);
    wait_x(50);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_x_busy", 128'({xo[0], bsy[0], bsy[1]}), 128'd0);
    chk("abort_partial", 128'({on[0], on[1]}), {112'd0, 8'd50, 8'd48});
    seen = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (tv[0] || tv[1]) seen = 1'b1;
    end
    chk("abort_no_valid", 128'(seen), 128'd0);

    do_start(2, '1);
    wait_x(90);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_tt", tto[0] | tto[1], 128'd0);
    chk("rst_mid_outs", 128'({xo[0], on[0], on[1], bsy[0], bsy[1]}), 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (tv[0] || tv[1]) seen = 1'b1;
    end
    chk("rst_no_valid", 128'(seen), 128'd0);

    do_start(0, '0);
    wait_valid(128, 130);
    chk("post_rst_tt", tto[0], {16{8'hAA}});
    chk("post_rst_match", 128'(mt[0]), 128'd0);
    accept();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
